// File: rtl/usart_pkg.sv
// Shared types and helpers for the USART receive/transmit blocks.
// Rx state encodings, default frame constants, majority vote.
package usart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DIV_WIDTH  = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/usart_baud_tick.sv
// Free-running reloadable divider: one-clock tick every divisor+1 clocks.
// Divisor is picked up at each reload, so changes apply on the next period.
module usart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_tick = w_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_zero) begin
      r_cnt <= i_divisor;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/usart_rx.sv
// Oversampling 8N1 receiver with majority voting, start-glitch rejection,
// framing and overrun detection; valid/ready byte output.
module usart_rx
  import usart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                 comm_clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_divisor,
  input  logic                 rx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 busy,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int M   = OVERSAMPLE / 2;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SCW-1:0] SC_A   = SCW'(M - 1);
  localparam logic [SCW-1:0] SC_B   = SCW'(M);
  localparam logic [SCW-1:0] SC_C   = SCW'(M + 1);
  localparam logic [SCW-1:0] SC_END = SCW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0]  IX_END = IW'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rxs;
  logic                 w_tick;

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [SCW-1:0]       r_sc;
  logic [SCW-1:0]       w_sc_nxt;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_s0;
  logic                 r_s1;
  logic                 w_s0_nxt;
  logic                 w_s1_nxt;
  logic                 r_deliver;
  logic                 w_deliver;
  logic                 r_ferr;
  logic                 w_ferr;

  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ovr;

  logic                 w_maj;
  logic                 w_at_a;
  logic                 w_at_b;
  logic                 w_at_c;
  logic                 w_at_end;
  logic [SCW-1:0]       w_sc_inc;

  usart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .i_clk     (comm_clock),
    .i_rst_n   (reset),
    .i_divisor (baud_divisor),
    .o_tick    (w_tick)
  );

  // Idle-high line: synchroniser resets to 1 so reset never fakes a start.
  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs    = r_sync2;
  assign w_maj    = maj3(r_s0, r_s1, w_rxs);
  assign w_at_a   = w_tick && (r_sc == SC_A);
  assign w_at_b   = w_tick && (r_sc == SC_B);
  assign w_at_c   = w_tick && (r_sc == SC_C);
  assign w_at_end = w_tick && (r_sc == SC_END);
  assign w_sc_inc = r_sc + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;

    if (w_at_a) w_s0_nxt = w_rxs;
    if (w_at_b) w_s1_nxt = w_rxs;

    unique case (r_state)
      RX_IDLE: begin
        if (w_tick && !w_rxs) begin
          w_state_nxt = RX_START;
          w_sc_nxt    = '0;
        end
      end
      RX_START: begin
        if (w_at_c && w_maj) begin
          w_state_nxt = RX_IDLE;
          w_sc_nxt    = '0;
        end else if (w_at_end) begin
          w_state_nxt = RX_DATA;
          w_sc_nxt    = '0;
          w_idx_nxt   = '0;
        end else if (w_tick) begin
          w_sc_nxt = w_sc_inc;
        end
      end
      RX_DATA: begin
        if (w_at_c) begin
          w_shift_nxt = (r_shift >> 1)
                      | (DATA_BITS'(w_maj) << (DATA_BITS - 1));
        end
        if (w_at_end) begin
          w_sc_nxt = '0;
          if (r_idx == IX_END) begin
            w_state_nxt = RX_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (w_tick) begin
          w_sc_nxt = w_sc_inc;
        end
      end
      // Stop bit is judged mid-bit so the next start edge is never missed.
      RX_STOP: begin
        if (w_at_c) begin
          w_sc_nxt = '0;
          if (w_maj) begin
            w_state_nxt = RX_IDLE;
            w_deliver   = 1'b1;
          end else begin
            w_state_nxt = RX_WAIT_IDLE;
            w_ferr      = 1'b1;
          end
        end else if (w_tick) begin
          w_sc_nxt = w_sc_inc;
        end
      end
      RX_WAIT_IDLE: begin
        if (w_tick && w_rxs) begin
          w_state_nxt = RX_IDLE;
          w_sc_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
        w_sc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      r_state   <= RX_IDLE;
      r_sc      <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_deliver <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sc      <= w_sc_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_s0      <= w_s0_nxt;
      r_s1      <= w_s1_nxt;
      r_deliver <= w_deliver;
      r_ferr    <= w_ferr;
    end
  end

  // A held byte is never overwritten; a simultaneous transfer frees the slot.
  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_deliver) begin
        if (!r_valid || out_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_data      = r_data;
  assign busy          = (r_state != RX_IDLE);
  assign framing_error = r_ferr;
  assign overrun_error = r_ovr;

endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
- Oversampling asynchronous serial receiver: recovers 8N1 frames from the `rx` pin and presents each byte on a valid/ready output.
- The output connects directly to sync_fifo's `in_valid`/`in_ready`/`in_data`; it is the producer stage of the receive path.
- Includes glitch rejection on the start bit, 3-sample majority voting, framing-error detection and overrun detection when the downstream stage stalls.

Parameters:
- DATA_BITS, 8: data bits per frame; LSB first, no parity, one stop bit.
- OVERSAMPLE, 16: oversample ticks per bit; must be even and ≥ 8.
- DIV_WIDTH, 16: width of `baud_divisor`.

Ports:
- comm_clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- baud_divisor  input  DIV_WIDTH  oversample tick period minus one, in clocks; sampled at each tick reload.
- rx  input  1  serial line; asynchronous; idles high.
- out_valid  output  1  byte available on `out_data`.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  DATA_BITS  received byte.
- busy  output  1  high whenever the state is not IDLE.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun_error  output  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset values: `out_valid`=0, `out_data`=0, `busy`=0, `framing_error`=0, `overrun_error`=0; state=IDLE; tick counter=0; both synchroniser flops=1.
- Reset may arrive mid-frame; it aborts the frame with no output and no error pulse.
- Synchroniser: `rx` passes through 2 flops; all decisions use the synchronised value `rxs`.
- Tick generator:
  - Down-counter reloads from `baud_divisor` and pulses `tick` when it reaches 0.
  - It is free-running, giving a tick period of `baud_divisor`+1 clocks.
  - `baud_divisor`=0 gives a tick every clock.
- Bit timing: sample counter `sc` runs 0..OVERSAMPLE-1 per bit and advances on `tick`. Samples are taken at `sc` = M-1, M, M+1, where M = OVERSAMPLE/2. The bit value is the majority of the three samples.
- State machine:
  - IDLE: on a tick with `rxs`=0, go to START with `sc`=0.
  - START: after sample M+1, if the majority is 1, return to IDLE (glitch rejected, no pulse). At `sc`=OVERSAMPLE-1, go to DATA with bit index 0.
  - DATA: the majority value is shifted in LSB first. After DATA_BITS bits complete (at `sc`=OVERSAMPLE-1 of the last bit), go to STOP.
  - STOP: evaluated after sample M+1, without waiting for the end of the bit.
    - Majority 1: deliver the byte and go to IDLE.
    - Majority 0: pulse `framing_error`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until a tick sees `rxs`=1, then go to IDLE. This handles a break condition.
- Output handshake:
  - The byte is delivered on the clock after the STOP evaluation.
  - If `out_valid`=0 or `out_ready`=1 in that cycle: `out_data` ← byte and `out_valid` ← 1.
  - Otherwise: pulse `overrun_error`, drop the new byte, keep the held byte.
  - `out_valid` and `out_data` are held stable until `out_ready`=1. A transfer clears `out_valid` unless it coincides with a delivery; in that case `out_valid` stays 1 with the new byte and no overrun is flagged.
- Latency: from the `rx` stop-bit edge, about (M+1) ticks plus 3 clocks (synchroniser plus register).

Decomposition:
- `usart_pkg` holds:
  - rx state encodings (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the default OVERSAMPLE and DATA_BITS constants;
  - the majority-of-3 function.
- Natural sub-module: `usart_baud_tick` (reloadable divider producing `tick`), reused by the future `usart_tx`.

Test Plan:
- Byte 0x55: `baud_divisor`=0 (16 clocks/bit), `out_ready`=1 → single `out_valid` beat with `out_data`=0x55; no error pulses; `busy` returns to 0.
- Start glitch: `rx` low for 4 clocks, then high → `busy` drops after the START check; no `out_valid`, no `framing_error`.
- Framing error: frame 0xA5 with stop bit 0 → `framing_error` pulses once and there is no `out_valid`. Then hold `rx` low 40 more clocks, release, and send 0x3C → 0x3C is received cleanly.
- Overrun: `out_ready`=0, send 0xAA then 0xBB → `out_data` stays 0xAA and `overrun_error` pulses once at the second byte. Then raise `out_ready` for 1 cycle → `out_valid` falls.
- Integration: drive sync_fifo with `baud_divisor`=2 (48 clocks/bit) and back-to-back frames 0x11, 0x22 → FIFO pops 0x11 then 0x22; `out_empty` deasserts after the first byte.
- Mid-frame reset: pull `reset` low during DATA bit 3 of 0xF0 → all outputs are 0 immediately. After release, frame 0x7E → `out_data`=0x7E with no error pulses.
